iterative_shifter: RTL and testbench
====================================

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; power of two, at least 2.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; equals log2(WIDTH).
REQ-003 SHALL have port clock  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port data_in  input  WIDTH  operand.
REQ-008 SHALL have port shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  shifted operand.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready high only in IDLE.
REQ-015 SHALL accept a request on a rising edge with in_valid and in_ready both high; data_in, shamt and mode are captured at that edge and ignored at all other times.
REQ-016 On accept with shamt=N>0, SHALL enter SHIFT with remaining count N; with N=0, SHALL enter DONE directly, result = data_in.
REQ-017 In SHIFT, SHALL shift the working register by exactly one bit per rising edge and decrement the count; after the edge where the count reaches 0, SHALL enter DONE.
REQ-018 One-bit step per mode: LSL inserts 0 at bit 0; LSR inserts 0 at bit WIDTH-1; ASR replicates bit WIDTH-1; ROR moves bit 0 into bit WIDTH-1; bits shifted out are discarded except in ROR.
REQ-019 Latency: out_valid SHALL be high exactly N rising edges after the accepting edge (N=0: immediately after the accepting edge); a transaction occupies N+1 edges plus output-stall time.
REQ-020 In DONE, out_valid SHALL be high and result SHALL hold stable until a rising edge with out_ready high, after which the state is IDLE and out_valid low.
REQ-021 out_ready SHALL have no effect outside DONE; out_valid SHALL be low outside DONE.
REQ-022 No new request SHALL be accepted in the edge that completes the output handshake; the next accept is possible at the following edge earliest.
REQ-023 result SHALL show the working register in all states; its value outside DONE is not guaranteed to be the final result.
REQ-024 mode and shamt changes during SHIFT or DONE SHALL not affect the transaction in flight.

Reset
REQ-025 While reset is high, SHALL immediately (no clock edge) force state IDLE, count 0, working register 0, out_valid 0, busy 0, in_ready 1.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abandon the transaction with no result delivered; the first accept is possible at the first rising edge after reset deasserts.

Verification (WIDTH=32)
REQ-027 data_in=0x9666B7A8, shamt=1, mode=LSL -> out_valid 1 edge after accept, result=0x2CCD6F50.
REQ-028 data_in=0x9666B7A8, shamt=4, mode=LSR then ASR -> results 0x09666B7A and 0xF9666B7A, each with out_valid 4 edges after accept.
REQ-029 data_in=0x9666B7A8, shamt=8, mode=ROR, out_ready low 3 cycles -> result 0xA89666B7 held stable, in_ready low until handshake.
REQ-030 shamt=0, any mode, data_in=0xDEADBEEF -> out_valid immediately after accepting edge, result=0xDEADBEEF.
REQ-031 shamt=31, LSL, data_in=0x00000001 -> result=0x80000000 after 31 edges; in_valid pulses mid-operation ignored.
REQ-032 Reset asserted 5 edges into shamt=20 operation -> out_valid 0, busy 0, in_ready 1 without a clock edge; next operation after reset returns a correct result.

Source files
------------

// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle barrel-shift replacement: shifts an operand by one bit per clock
// until the requested amount has been applied, then holds the result until the
// consumer takes it. Supports logical left, logical right, arithmetic right and
// rotate right.
//
// Ports
//   clock      sole clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   request strobe, accepted when in_ready is also high
//   in_ready   high only while idle
//   data_in    operand (captured on accept only)
//   shamt      shift amount 0..WIDTH-1 (captured on accept only)
//   mode       00 LSL, 01 LSR, 10 ASR, 11 ROR (captured on accept only)
//   out_valid  result available (DONE state)
//   out_ready  consumer takes the result
//   result     working register; final value only while out_valid is high
//   busy       high whenever the block is not idle
// -----------------------------------------------------------------------------
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    state_t             state_reg;
    logic [SHAMT_W-1:0] count_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [1:0]         mode_reg;
    logic               out_valid_reg;
    logic               in_ready_reg;
    logic               busy_reg;

    // One-bit step of the working register for the captured mode.
    logic [WIDTH-1:0]   step_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == WIDTH - 1) begin : g_msb
                // Top bit: the fill value is what distinguishes the right shifts.
                always_comb begin
                    step_next[gi] = work_reg[0];                  // ROR
                    if (mode_reg == MODE_LSL)
                        step_next[gi] = work_reg[gi-1];
                    else if (mode_reg == MODE_LSR)
                        step_next[gi] = 1'b0;
                    else if (mode_reg == MODE_ASR)
                        step_next[gi] = work_reg[gi];
                end
            end else if (gi == 0) begin : g_lsb
                assign step_next[gi] = (mode_reg == MODE_LSL) ? 1'b0 : work_reg[gi+1];
            end else begin : g_mid
                assign step_next[gi] = (mode_reg == MODE_LSL) ? work_reg[gi-1] : work_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            work_reg      <= '0;
            mode_reg      <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg     <= data_in;
                        mode_reg     <= mode;
                        count_reg    <= shamt;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (shamt == '0) begin
                            // Nothing to shift: result is the operand itself.
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg  <= step_next;
                    count_reg <= count_reg - SHAMT_W'(1);
                    // The edge applying the last step also enters DONE, so the
                    // result appears exactly shamt edges after the accept.
                    if (count_reg == SHAMT_W'(1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here (rather than accepting directly)
                    // keeps a one-edge gap between handshake and next accept.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign result    = work_reg;

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// tb_iterative_shifter
//
// Self-checking bench for iterative_shifter (WIDTH=32). Expected results and
// latencies are pushed to queues when a request is accepted and popped when
// the DUT raises out_valid. Outputs are sampled 1 time unit after the rising
// edge.
// -----------------------------------------------------------------------------
module tb_iterative_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    iterative_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: whole-amount shift, independent of the one-bit stepping.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
        logic [63:0] dd;
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return dd[31:0];
            end
        endcase
    endfunction

    // One full transaction: accept, wait for out_valid, stall, handshake.
    task automatic run_op(input logic [31:0] d, input int s, input logic [1:0] m,
                          input int stall, input bit noise);
        int edges;
        logic [31:0] got;
        logic [31:0] expv;
        int explat;

        // Drive the request mid-cycle, away from the edge.
        chk("in_ready_before", {31'b0, in_ready}, 32'd1);
        data_in  = d;
        shamt    = SHAMT_W'(s);
        mode     = m;
        in_valid = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(ref_shift(d, s, m));
        lat_q.push_back(s);
        @(posedge clock);
        #1;
        // Scramble operands after the accept; the transaction must not see them.
        in_valid = 1'b0;
        data_in  = $urandom;
        shamt    = SHAMT_W'($urandom);
        mode     = 2'($urandom);
        edges = 0;
        if (s != 0) begin
            chk("busy_shift", {31'b0, busy}, 32'd1);
            chk("in_ready_shift", {31'b0, in_ready}, 32'd0);
        end
        while (!out_valid && edges <= 100) begin
            if (noise) begin
                in_valid = 1'($urandom);
                data_in  = $urandom;
                shamt    = SHAMT_W'($urandom);
                mode     = 2'($urandom);
            end
            @(posedge clock);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        explat = lat_q.pop_front();
        expv   = exp_q.pop_front();
        if (edges > 100) begin
            chk("timeout", 32'(edges), 32'(explat));
            return;
        end
        chk("latency", 32'(edges), 32'(explat));
        got = result;
        chk("result", got, expv);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_hold", result, expv);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        // Handshake edge with a competing request: it must not be accepted.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_busy", {31'b0, busy}, 32'd0);
        $display("txn d=%h shamt=%0d mode=%0d stall=%0d -> result=%h latency=%0d",
                 d, s, m, stall, got, edges);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        shamt     = '0;
        mode      = '0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #2;

        run_op(32'h9666B7A8, 1, 2'b00, 0, 1'b0);
        chk("req027_const", ref_shift(32'h9666B7A8, 1, 2'b00), 32'h2CCD6F50);
        run_op(32'h9666B7A8, 4, 2'b01, 0, 1'b0);
        run_op(32'h9666B7A8, 4, 2'b10, 0, 1'b0);
        run_op(32'h9666B7A8, 8, 2'b11, 3, 1'b0);
        for (int m = 0; m < 4; m++)
            run_op(32'hDEADBEEF, 0, 2'(m), 1, 1'b0);
        run_op(32'h00000001, 31, 2'b00, 0, 1'b1);
        run_op(32'h80000001, 31, 2'b10, 0, 1'b1);
        run_op(32'h80000001, 31, 2'b11, 2, 1'b1);
        for (int i = 0; i < 8; i++)
            run_op($urandom, int'($urandom_range(0, 31)), 2'($urandom), int'($urandom_range(0, 2)), 1'b1);

        // Reset mid-shift: 5 edges into a shamt=20 operation.
        data_in  = 32'h12345678;
        shamt    = 5'd20;
        mode     = 2'b00;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
        end
        #2;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        run_op(32'h9666B7A8, 4, 2'b10, 0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
